// File: rtl/backing_store_if.sv
// Request/response bus between a cache (initiator) and the backing store
// (responder).
//
// Handshake: the initiator holds req_addr/req_data/req_type valid and raises
// req_do for at least one cycle while busy=0. The responder accepts on that
// clock edge and raises busy. req_do seen while busy=1 is ignored, except
// during the post-reset clear, where the last such request is held and then
// serviced. Completion is a single-cycle req_done pulse. O_data carries read
// data during that cycle only and is 0 at every other time.
interface backing_store_if;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        req_type;
  logic        req_do;
  logic [31:0] O_data;
  logic        req_done;
  logic        busy;

  modport master (
    output req_addr, req_data, req_type, req_do,
    input  O_data, req_done, busy
  );

  modport slave (
    input  req_addr, req_data, req_type, req_do,
    output O_data, req_done, busy
  );
endinterface

// File: rtl/backing_store.sv
// Word-addressed main-memory model answering cache miss / write-through
// requests. It holds one request at a time, waits LATENCY cycles and then
// performs the access. After every reset it clears the whole array before
// it reports ready.
module backing_store #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4
) (
  input  logic            clk,
  input  logic            reset,        // asynchronous, active-low
  backing_store_if.slave  bus,
  output logic [1:0]      o_dbg_state   // FSM state, for observation
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  // Out-of-range parameters stop elaboration.
  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("backing_store: LATENCY must be in 1..255");
  end
  if (ADDR_BITS < 1 || ADDR_BITS > 29) begin : g_bad_addr_bits
    $error("backing_store: ADDR_BITS must be in 1..29");
  end

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Storage: no reset, the Init sweep clears it.
  logic [31:0] r_mem [DEPTH];

  state_t                 r_state;
  logic [ADDR_BITS-1:0]   r_sweep;
  logic [7:0]             r_cnt;
  logic                   r_pending;
  logic [ADDR_BITS-1:0]   r_idx;
  logic [31:0]            r_data;
  logic                   r_type;
  logic [31:0]            r_rd_data;

  state_t                 w_state_n;
  logic [ADDR_BITS-1:0]   w_sweep_n;
  logic [7:0]             w_cnt_n;
  logic                   w_pending_n;
  logic                   w_latch;
  logic                   w_mem_we;
  logic [ADDR_BITS-1:0]   w_mem_waddr;
  logic [31:0]            w_mem_wdata;
  logic                   w_rd_en;
  logic [ADDR_BITS-1:0]   w_req_idx;

  // Byte offset and the address bits above the array alias away.
  assign w_req_idx = bus.req_addr[ADDR_BITS+1:2];

  logic w_unused_addr;
  assign w_unused_addr = ^{bus.req_addr[31:ADDR_BITS+2], bus.req_addr[1:0]};

  // Next-state, sweep/counter updates and memory-port controls.
  always_comb begin
    w_state_n   = r_state;
    w_sweep_n   = r_sweep;
    w_cnt_n     = r_cnt;
    w_pending_n = r_pending;
    w_latch     = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_waddr = r_idx;
    w_mem_wdata = r_data;
    w_rd_en     = 1'b0;

    case (r_state)
      S_INIT: begin
        w_mem_we    = 1'b1;
        w_mem_waddr = r_sweep;
        w_mem_wdata = 32'd0;
        w_sweep_n   = r_sweep + 1'b1;
        // A request arriving during the clear is held, and a newer one replaces it.
        if (bus.req_do) begin
          w_latch     = 1'b1;
          w_pending_n = 1'b1;
        end
        if (r_sweep == {ADDR_BITS{1'b1}}) begin
          w_sweep_n = '0;
          if (r_pending || bus.req_do) begin
            w_state_n   = S_WAIT;
            w_cnt_n     = LAT_M1;
            w_pending_n = 1'b0;
          end else begin
            w_state_n = S_IDLE;
          end
        end
      end

      S_IDLE: begin
        if (bus.req_do) begin
          w_latch   = 1'b1;
          w_cnt_n   = LAT_M1;
          w_state_n = S_WAIT;
        end
      end

      S_WAIT: begin
        // New requests are ignored here; there is no queue.
        if (r_cnt != 8'd0) begin
          w_cnt_n = r_cnt - 8'd1;
        end else begin
          if (r_type) w_mem_we = 1'b1;
          else        w_rd_en  = 1'b1;
          w_state_n = S_DONE;
        end
      end

      S_DONE: begin
        w_state_n = S_IDLE;
      end

      default: begin
        w_state_n = S_INIT;
      end
    endcase
  end

  // State, sweep index, counter, request latch and read register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_INIT;
      r_sweep   <= '0;
      r_cnt     <= 8'd0;
      r_pending <= 1'b0;
      r_idx     <= '0;
      r_data    <= 32'd0;
      r_type    <= 1'b0;
      r_rd_data <= 32'd0;
    end else begin
      r_state   <= w_state_n;
      r_sweep   <= w_sweep_n;
      r_cnt     <= w_cnt_n;
      r_pending <= w_pending_n;
      if (w_latch) begin
        r_idx  <= w_req_idx;
        r_data <= bus.req_data;
        r_type <= bus.req_type;
      end
      if (w_rd_en) begin
        r_rd_data <= r_mem[r_idx];
      end
    end
  end

  // Array write port; no writes while reset is held.
  always_ff @(posedge clk) begin
    if (w_mem_we && reset) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Outputs are decoded from registered state only.
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.req_done = (r_state == S_DONE);
  assign bus.O_data   = (r_state == S_DONE && !r_type) ? r_rd_data : 32'd0;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_backing_store.sv
// Directed bench for backing_store: a 1024-word LATENCY=4 instance plus a
// 16-word LATENCY=1 instance, with per-instance expected-data queues drained
// by completion monitors.
module tb_backing_store;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  backing_store_if bus0();
  backing_store_if bus1();
  logic [1:0] dbg0, dbg1;

  backing_store #(.ADDR_BITS(10), .LATENCY(4)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .o_dbg_state(dbg0)
  );
  backing_store #(.ADDR_BITS(4), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .o_dbg_state(dbg1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
  endtask

  // Completion monitor for the LATENCY=4 instance.
  always @(negedge clk) begin
    if (bus0.req_done === 1'b1) begin
      if (exp0_q.size() == 0) chk("done0_unexpected", {31'd0, bus0.req_done}, 32'd0);
      else                    chk("rdata0", bus0.O_data, exp0_q.pop_front());
    end else begin
      chk("odata0_quiet", bus0.O_data, 32'd0);
    end
  end

  // Completion monitor for the LATENCY=1 instance.
  always @(negedge clk) begin
    if (bus1.req_done === 1'b1) begin
      if (exp1_q.size() == 0) chk("done1_unexpected", {31'd0, bus1.req_done}, 32'd0);
      else                    chk("rdata1", bus1.O_data, exp1_q.pop_front());
    end else begin
      chk("odata1_quiet", bus1.O_data, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic req0(input logic [31:0] a, input logic [31:0] d, input logic t,
                      input logic [31:0] expv, input string tag);
    int cyc;
    @(negedge clk);
    bus0.req_addr = a; bus0.req_data = d; bus0.req_type = t; bus0.req_do = 1'b1;
    exp0_q.push_back(expv);
    @(negedge clk);
    bus0.req_do = 1'b0;
    cyc = 0;
    while (bus0.req_done !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd4);
    @(negedge clk);
    chk({tag, "_busy_after"}, {31'd0, bus0.busy}, 32'd0);
  endtask

  task automatic req1(input logic [31:0] a, input logic [31:0] d, input logic t,
                      input logic [31:0] expv, input string tag);
    int cyc;
    @(negedge clk);
    bus1.req_addr = a; bus1.req_data = d; bus1.req_type = t; bus1.req_do = 1'b1;
    exp1_q.push_back(expv);
    @(negedge clk);
    bus1.req_do = 1'b0;
    cyc = 0;
    while (bus1.req_done !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd1);
    @(negedge clk);
    chk({tag, "_busy_after"}, {31'd0, bus1.busy}, 32'd0);
  endtask

  task automatic wait_idle0(input string tag);
    int cyc;
    cyc = 0;
    while (bus0.busy !== 1'b0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_idle"}, {31'd0, bus0.busy}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    reset = 1'b0;
    bus0.req_addr = '0; bus0.req_data = '0; bus0.req_type = 1'b0; bus0.req_do = 1'b0;
    bus1.req_addr = '0; bus1.req_data = '0; bus1.req_type = 1'b0; bus1.req_do = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_state0", {30'd0, dbg0}, {30'd0, ST_INIT});
    chk("rst_busy0",  {31'd0, bus0.busy}, 32'd1);
    chk("rst_done0",  {31'd0, bus0.req_done}, 32'd0);
    chk("rst_state1", {30'd0, dbg1}, {30'd0, ST_INIT});

    // Init length: busy for exactly DEPTH cycles after release.
    reset = 1'b1;
    cyc = 0;
    while (bus0.busy === 1'b1 && cyc < 3000) begin
      cyc++;
      @(negedge clk);
    end
    chk("init_len", 32'(cyc), 32'd1024);
    chk("init_to_idle", {30'd0, dbg0}, {30'd0, ST_IDLE});

    // Cleared memory, write/read-back, aliasing.
    req0(32'h0000_0100, 32'h0, 1'b0, 32'h0000_0000, "rd_cleared");
    req0(32'h0000_0040, 32'hDEAD_BEEF, 1'b1, 32'h0, "wr_40");
    req0(32'h0000_0040, 32'h0, 1'b0, 32'hDEAD_BEEF, "rd_40");
    req0(32'h0000_1043, 32'h1234_5678, 1'b1, 32'h0, "wr_alias");
    req0(32'h0000_0040, 32'h0, 1'b0, 32'h1234_5678, "rd_alias");
    req0(32'h0000_0044, 32'h0, 1'b0, 32'h0000_0000, "rd_neighbour");

    // Second request during Wait is ignored: exactly one completion.
    @(negedge clk);
    bus0.req_addr = 32'h40; bus0.req_type = 1'b0; bus0.req_do = 1'b1;
    exp0_q.push_back(32'h1234_5678);
    @(negedge clk);
    bus0.req_do = 1'b0;
    @(negedge clk);
    bus0.req_addr = 32'h80; bus0.req_data = 32'hFFFF_0000; bus0.req_type = 1'b1;
    bus0.req_do = 1'b1;
    @(negedge clk);
    bus0.req_do = 1'b0;
    cyc = 0;
    while (bus0.req_done !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    chk("wait_ign_done", {31'd0, bus0.req_done}, 32'd1);
    @(negedge clk);
    chk("wait_ign_busy", {31'd0, bus0.busy}, 32'd0);
    repeat (8) @(negedge clk);
    req0(32'h0000_0080, 32'h0, 1'b0, 32'h0000_0000, "rd_ignored_wr");

    // LATENCY=1 instance.
    req1(32'h0000_0008, 32'hCAFE_F00D, 1'b1, 32'h0, "l1_wr");
    req1(32'h0000_0008, 32'h0, 1'b0, 32'hCAFE_F00D, "l1_rd");
    req1(32'h0000_0048, 32'h0, 1'b0, 32'hCAFE_F00D, "l1_alias");

    // Request during Init is held and serviced afterwards.
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    cyc = 0;
    repeat (10) begin
      @(negedge clk);
      cyc++;
    end
    bus0.req_addr = 32'h8; bus0.req_data = 32'hA5A5_A5A5; bus0.req_type = 1'b1;
    bus0.req_do = 1'b1;
    exp0_q.push_back(32'h0);
    chk("init_req_state", {30'd0, dbg0}, {30'd0, ST_INIT});
    @(negedge clk);
    cyc++;
    bus0.req_do = 1'b0;
    while (bus0.req_done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("init_req_done_at", 32'(cyc), 32'd1028);
    @(negedge clk);
    req0(32'h0000_0008, 32'h0, 1'b0, 32'hA5A5_A5A5, "rd_init_req");

    // Reset during Wait aborts the write.
    @(negedge clk);
    bus0.req_addr = 32'h20; bus0.req_data = 32'h1111_1111; bus0.req_type = 1'b1;
    bus0.req_do = 1'b1;
    @(negedge clk);
    bus0.req_do = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy",  {31'd0, bus0.busy}, 32'd1);
    chk("abort_state", {30'd0, dbg0}, {30'd0, ST_INIT});
    chk("abort_done",  {31'd0, bus0.req_done}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_idle0("abort_reinit");
    req0(32'h0000_0020, 32'h0, 1'b0, 32'h0000_0000, "rd_aborted");

    chk("q0_drained", 32'(exp0_q.size()), 32'd0);
    chk("q1_drained", 32'(exp1_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/backing_store.md
Name: backing_store

Overview:
- Word-addressed main-memory model that answers cache miss and write-through requests; the responder end of the cache's req_do/req_done interface.
- Accepts one request at a time and waits a programmable number of cycles.
- Performs the read or write, then pulses req_done for one cycle with read data on O_data.
- Clears its whole array after every reset, before it reports ready.

Parameters:
- ADDR_BITS, 10, word-index width; DEPTH = 2**ADDR_BITS 32-bit words.
- LATENCY, 4, cycles from request acceptance to memory access; legal range 1..255.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low; 0 = reset asserted.
- req_addr  input  32  byte address; index = req_addr[ADDR_BITS+1:2]; [1:0] and bits above ADDR_BITS+1 ignored (aliasing).
- req_data  input  32  write data.
- req_type  input  1  0 = read, 1 = write.
- req_do  input  1  request strobe; one-cycle pulse is sufficient.
- O_data  output  32  read data; nonzero only while req_done=1 for a read.
- req_done  output  1  one-cycle completion pulse.
- busy  output  1  1 in every state except Idle.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=Init, sweep index=0, counter=0, pending=0.
  - Latched addr/data/type=0, read register=0.
  - O_data=0, req_done=0, busy=1.
  - The array is not cleared by async reset; the Init sweep clears it.
- States are Init, Idle, Wait, Done.
- Init:
  - Writes 0 to word[sweep index] each cycle, then increments the index.
  - After the write to DEPTH-1, go to Idle, or to Wait if pending=1.
  - Takes exactly DEPTH cycles after reset release.
- Request capture during Init:
  - req_do=1 latches addr/data/type and sets pending=1.
  - A later req_do during Init overwrites the latch (last request wins).
  - Leaving Init for Wait loads counter=LATENCY-1 and clears pending.
- Idle:
  - req_do=1 at edge E0 latches req_addr, req_data, req_type; counter=LATENCY-1; go to Wait.
  - req_do=0 stays in Idle.
- Wait:
  - counter!=0: decrement.
  - counter==0 (edge E0+LATENCY):
    - Write: commit latched data to word[index].
    - Read: register word[index] into the read register.
    - Go to Done.
  - req_do is ignored in Wait; no queueing and no error.
- Done:
  - Lasts one cycle (after E0+LATENCY, up to E0+LATENCY+1).
  - req_done=1.
  - O_data = read register for reads, 0 for writes.
  - Next state is Idle; req_do in Done is ignored.
- Latency: req_done is high exactly LATENCY cycles after the accepting edge. With LATENCY=1, req_done is seen the cycle after req_do, which is compatible with an initiator that pulses req_do then waits.
- Outputs are registered or state-decoded only; no combinational path from req_* to outputs.
- A read issued immediately after a write to the same index returns the new data; ordering is strict.
- O_data is 0 whenever req_done=0.
- Reset mid-operation:
  - Aborts the current request; no req_done is produced.
  - A write whose access edge has not occurred is not committed.
  - Init re-clears the array regardless.
- LATENCY is 8-bit internally; values outside 1..255 are illegal (elaboration check).

Test Plan:
- Release reset, hold req_do=0 -> busy=1 for exactly 1024 cycles, then 0. Read 0x0000_0100 -> req_done 4 cycles after accept, O_data=0x0000_0000.
- After Init, write 0x0000_0040 / 0xDEADBEEF -> req_done pulse 4 cycles later with O_data=0. Then read 0x0000_0040 -> O_data=0xDEADBEEF only in the req_done cycle, 0 in the cycles before and after.
- Aliasing: write 0x0000_1043 / 0x12345678, then read 0x0000_0040 -> 0x12345678 (both map to index 0x010).
- req_do write 0x8 / 0xA5A5A5A5 at cycle 10 after reset (during Init) -> serviced after Init. req_done at cycle 1024+4 relative to reset release; a subsequent read of 0x8 returns 0xA5A5A5A5.
- Read accepted in Idle, second req_do during Wait -> exactly one req_done, and busy returns to 0 after the Done cycle. LATENCY=1 build: req_done the cycle after accept.
- Write in flight, reset=0 during Wait -> req_done never asserts, busy=1, Init restarts. A later read of that address returns 0.
